tick_scheduler: RTL and testbench

- Multi-channel game-tick scheduler clocked by the 1 ms tick; replaces per-object fixed-period dividers such as the 150 ms move tick.
- Each channel (player, demon, bullet, animation) has a programmable period in ms.
- Expiries are queued and handed one at a time to the shared position-update datapath through a valid/ack handshake with round-robin fairness.

---
 rtl/tick_scheduler_pkg.sv | 20 ++
 rtl/tick_channel.sv | 58 +++++
 rtl/tick_scheduler.sv | 129 ++++++++++++
 tb/tb_tick_scheduler.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/tick_scheduler_pkg.sv
// rtl/tick_scheduler_pkg.sv - shared constants and types for the tick scheduler
package tick_scheduler_pkg;

    localparam int N_CH = 4;
    localparam int CW   = 2;
    localparam int PW   = 9;

    localparam logic [PW-1:0] DEF_PERIOD = 9'd150;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [CW-1:0] CH_PLAYER = 2'd0;
    localparam logic [CW-1:0] CH_DEMON  = 2'd1;
    localparam logic [CW-1:0] CH_BULLET = 2'd2;
    localparam logic [CW-1:0] CH_ANIM   = 2'd3;

endpackage

// File: rtl/tick_channel.sv
// rtl/tick_channel.sv - one tick channel: period register, counter, pending and overrun flags
module tick_channel
    import tick_scheduler_pkg::*;
(
    input  logic          clk_1ms,
    input  logic          reset,
    input  logic          pause,
    input  logic          en,
    input  logic          cfg_we,
    input  logic [PW-1:0] cfg_period,
    input  logic          granted,
    input  logic          clear,
    output logic          pending,
    output logic          overrun
);

    logic [PW-1:0] period;
    logic [PW-1:0] cnt;
    logic          active;
    logic          expire;

    // A period of 0 parks the channel; pause freezes the count but not the drain.
    always_comb begin
        active = en & ~pause & (period != '0);
        expire = active & (cnt == period - PW'(1));
    end

    // Counter and flag update; a config write outranks an expiry in the same cycle.
    always_ff @(posedge clk_1ms) begin
        if (!reset) begin
            cnt     <= '0;
            period  <= DEF_PERIOD;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else if (cfg_we) begin
            period  <= cfg_period;
            cnt     <= '0;
            overrun <= 1'b0;
            // An in-flight grant must still see its tick through to the ack.
            pending <= granted & pending & ~clear;
        end else if (!en) begin
            cnt     <= '0;
            pending <= granted & pending & ~clear;
        end else begin
            if (active)
                cnt <= expire ? '0 : cnt + PW'(1);
            if (expire) begin
                // Ticks merge: a second expiry before the first is consumed is flagged.
                pending <= 1'b1;
                if (pending & ~clear)
                    overrun <= 1'b1;
            end else if (clear) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - multi-channel game-tick scheduler with round-robin grant handshake
module tick_scheduler
    import tick_scheduler_pkg::*;
(
    input  logic            clk_1ms,
    input  logic            reset,
    input  logic            pause,
    input  logic [N_CH-1:0] ch_en,
    input  logic            cfg_valid,
    input  logic [CW-1:0]   cfg_ch,
    input  logic [PW-1:0]   cfg_period,
    output logic            cfg_ready,
    output logic            grant_valid,
    output logic [CW-1:0]   grant_ch,
    output logic [N_CH-1:0] grant,
    input  logic            grant_ack,
    output logic [N_CH-1:0] overrun
);

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   last;
    logic [CW-1:0]   last_nx;
    logic [CW-1:0]   grant_ch_nx;
    logic [N_CH-1:0] grant_nx;
    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] cfg_we;
    logic [N_CH-1:0] granted;
    logic [N_CH-1:0] clear;
    logic            pick_found;
    logic [CW-1:0]   pick_ch;
    logic [CW-1:0]   cand;

    assign grant_valid = (state == ST_GRANT);

    // Config port is closed only while reset is being applied.
    always_ff @(posedge clk_1ms) begin
        if (!reset)
            cfg_ready <= 1'b0;
        else
            cfg_ready <= 1'b1;
    end

    // Per-channel strobes: config write select, current grant owner, and ack clear.
    always_comb begin
        cfg_we  = '0;
        granted = '0;
        clear   = '0;
        for (int i = 0; i < N_CH; i++) begin
            cfg_we[i]  = cfg_valid & cfg_ready & (cfg_ch == CW'(i));
            granted[i] = grant_valid & (grant_ch == CW'(i));
            clear[i]   = granted[i] & grant_ack;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        tick_channel u_ch (
            .clk_1ms    (clk_1ms),
            .reset      (reset),
            .pause      (pause),
            .en         (ch_en[g]),
            .cfg_we     (cfg_we[g]),
            .cfg_period (cfg_period),
            .granted    (granted[g]),
            .clear      (clear[g]),
            .pending    (pending[g]),
            .overrun    (overrun[g])
        );
    end

    // Round-robin pick: scan last+N_CH down to last+1 so the nearest successor wins.
    // Index arithmetic wraps in CW bits, which relies on N_CH being 2**CW.
    always_comb begin
        pick_found = 1'b0;
        pick_ch    = last;
        cand       = last;
        for (int k = N_CH; k >= 1; k--) begin
            cand = last + CW'(k);
            if (pending[cand]) begin
                pick_found = 1'b1;
                pick_ch    = cand;
            end
        end
    end

    // Arbiter next-state: offer one tick, hold it stable until acked.
    always_comb begin
        state_nx    = state;
        grant_ch_nx = grant_ch;
        grant_nx    = grant;
        last_nx     = last;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    state_nx    = ST_GRANT;
                    grant_ch_nx = pick_ch;
                    grant_nx    = N_CH'(1) << pick_ch;
                end
            end
            ST_GRANT: begin
                if (grant_ack) begin
                    state_nx = ST_IDLE;
                    last_nx  = grant_ch;
                    grant_nx = '0;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                grant_nx = '0;
            end
        endcase
    end

    // Arbiter registers; last starts at the top channel so channel 0 goes first.
    always_ff @(posedge clk_1ms) begin
        if (!reset) begin
            state    <= ST_IDLE;
            grant_ch <= '0;
            grant    <= '0;
            last     <= CW'(N_CH - 1);
        end else begin
            state    <= state_nx;
            grant_ch <= grant_ch_nx;
            grant    <= grant_nx;
            last     <= last_nx;
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// tb/tb_tick_scheduler.sv - directed self-checking bench for tick_scheduler
module tb_tick_scheduler;
    import tick_scheduler_pkg::*;

    logic            clk_1ms;
    logic            reset;
    logic            pause;
    logic [N_CH-1:0] ch_en;
    logic            cfg_valid;
    logic [CW-1:0]   cfg_ch;
    logic [PW-1:0]   cfg_period;
    logic            cfg_ready;
    logic            grant_valid;
    logic [CW-1:0]   grant_ch;
    logic [N_CH-1:0] grant;
    logic            grant_ack;
    logic [N_CH-1:0] overrun;

    int n_checks = 0;
    int n_err    = 0;

    int gk[$];
    int gc[$];
    int gg[$];
    int ek[16];
    int ec[16];

    tick_scheduler dut (
        .clk_1ms     (clk_1ms),
        .reset       (reset),
        .pause       (pause),
        .ch_en       (ch_en),
        .cfg_valid   (cfg_valid),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_ready   (cfg_ready),
        .grant_valid (grant_valid),
        .grant_ch    (grant_ch),
        .grant       (grant),
        .grant_ack   (grant_ack),
        .overrun     (overrun)
    );

    initial clk_1ms = 1'b0;
    always #5 clk_1ms = ~clk_1ms;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_1ms);
        #1;
    endtask

    task automatic cap(input int n);
        gk.delete();
        gc.delete();
        gg.delete();
        for (int k = 1; k <= n; k++) begin
            tick();
            if (grant_valid === 1'b1) begin
                gk.push_back(k);
                gc.push_back(int'(grant_ch));
                gg.push_back(int'(grant));
            end
        end
    endtask

    task automatic set_exp(input int j, input int k, input int c);
        ek[j] = k;
        ec[j] = c;
    endtask

    task automatic chk_grants(input string tag, input int n);
        check({tag, "_count"}, gk.size(), n);
        for (int j = 0; j < n && j < gk.size(); j++) begin
            check($sformatf("%s_cyc%0d", tag, j), gk[j], ek[j]);
            check($sformatf("%s_ch%0d", tag, j), gc[j], ec[j]);
            check($sformatf("%s_onehot%0d", tag, j), gg[j], 32'd1 << ec[j]);
        end
    endtask

    task automatic cfg_write(input int ch, input int per);
        cfg_valid  = 1'b1;
        cfg_ch     = CW'(ch);
        cfg_period = PW'(per);
        tick();
        cfg_valid  = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        pause      = 1'b0;
        ch_en      = '1;
        cfg_valid  = 1'b0;
        cfg_ch     = '0;
        cfg_period = '0;
        grant_ack  = 1'b1;

        // Reset state
        repeat (3) tick();
        check("rst_grant_valid", grant_valid, 0);
        check("rst_grant", grant, 0);
        check("rst_grant_ch", grant_ch, 0);
        check("rst_cfg_ready", cfg_ready, 0);
        check("rst_overrun", overrun, 0);

        // Defaults, ack tied high: 0,1,2,3 two apart from cycle 151, again 150 later
        reset = 1'b1;
        cap(310);
        set_exp(0, 151, 0); set_exp(1, 153, 1); set_exp(2, 155, 2); set_exp(3, 157, 3);
        set_exp(4, 301, 0); set_exp(5, 303, 1); set_exp(6, 305, 2); set_exp(7, 307, 3);
        chk_grants("t1", 8);
        check("t1_cfg_ready", cfg_ready, 1);
        check("t1_overrun", overrun, 0);

        // ch1 period 5 alone, then period 0 parks it
        ch_en = 4'b0010;
        cfg_write(1, 5);
        cap(22);
        set_exp(0, 6, 1); set_exp(1, 11, 1); set_exp(2, 16, 1); set_exp(3, 21, 1);
        chk_grants("t2", 4);
        cfg_write(1, 0);
        cap(20);
        chk_grants("t2_park", 0);
        check("t2_overrun", overrun, 0);

        // ch0 period 3 with ack held low: grant held, overrun after second expiry
        ch_en     = 4'b0001;
        grant_ack = 1'b0;
        cfg_write(0, 3);
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("t3_valid_k%0d", k), grant_valid, (k >= 4) ? 1 : 0);
            check($sformatf("t3_ovr_k%0d", k), overrun, (k >= 6) ? 1 : 0);
            if (k >= 4) begin
                check($sformatf("t3_gch_k%0d", k), grant_ch, 0);
                check($sformatf("t3_grant_k%0d", k), grant, 1);
            end
        end
        grant_ack = 1'b1;
        tick();
        check("t3_after_ack_valid", grant_valid, 0);
        ch_en = 4'b0000;
        cap(5);
        chk_grants("t3_single", 0);
        check("t3_ovr_sticky", overrun, 1);

        // ch2 pending at pause: still drained, next expiry slips by 20 cycles
        ch_en     = 4'b0100;
        grant_ack = 1'b0;
        cfg_write(2, 4);
        repeat (4) tick();
        check("t4_pre_valid", grant_valid, 0);
        pause     = 1'b1;
        grant_ack = 1'b1;
        cap(20);
        set_exp(0, 1, 2);
        chk_grants("t4_pause", 1);
        pause = 1'b0;
        cap(10);
        set_exp(0, 5, 2); set_exp(1, 9, 2);
        chk_grants("t4_resume", 2);

        // Reset while a grant is outstanding
        grant_ack = 1'b0;
        for (int k = 0; k < 10 && grant_valid !== 1'b1; k++)
            tick();
        check("t6_grant_seen", grant_valid, 1);
        check("t6_ovr_before", overrun, 1);
        reset = 1'b0;
        tick();
        check("t6_valid", grant_valid, 0);
        check("t6_grant", grant, 0);
        check("t6_grant_ch", grant_ch, 0);
        check("t6_overrun", overrun, 0);
        check("t6_cfg_ready", cfg_ready, 0);
        reset     = 1'b1;
        grant_ack = 1'b1;
        cap(160);
        set_exp(0, 151, 2);
        chk_grants("t6_after", 1);

        // All channels period 1: strict rotation 0,1,2,3 and every overrun set
        reset = 1'b0;
        ch_en = 4'b0000;
        tick();
        reset = 1'b1;
        tick();
        for (int c = 0; c < N_CH; c++)
            cfg_write(c, 1);
        check("t5_ovr_clear", overrun, 0);
        ch_en = 4'b1111;
        cap(16);
        for (int j = 0; j < 8; j++)
            set_exp(j, 2 + 2 * j, j % N_CH);
        chk_grants("t5", 8);
        check("t5_overrun", overrun, 4'hF);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
